// File: rtl/bus_client_gen.sv
// Traffic-generating client for the arbitrated shared bus. It runs a legacy or a
// write-then-readback pattern with an enable gate, a request timeout and status counters.
module bus_client_gen #(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int REQUEST_DELAY        = 10,
    parameter int MODE                 = 0,
    parameter int MAX_WAIT             = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  rq,
    input  logic                  ack,
    output logic                  wr_ni,
    output logic [DATA_WIDTH-1:0] dataW,
    input  logic [DATA_WIDTH-1:0] dataR,
    output logic [15:0]           txn_count,
    output logic [7:0]            err_count,
    output logic [7:0]            timeout_count,
    output logic                  err
);

    typedef enum logic {ST_WAIT = 1'b0, ST_REQ = 1'b1} state_t;

    localparam int DLY_W = $clog2(REQUEST_DELAY + 2);
    localparam int WT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [DLY_W-1:0]      DLY_MAX = DLY_W'(REQUEST_DELAY);
    localparam logic [WT_W-1:0]       WT_LAST = WT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_WIDTH-1:0] A_BEG   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
    localparam logic [ADDR_WIDTH-1:0] A_END   = ADDR_WIDTH'(ADDR_SPACE_END);
    localparam logic                  CHECK_MODE = (MODE == 1);

    state_t                  state_r, state_s;
    logic [DLY_W-1:0]        dly_r, dly_s;
    logic [WT_W-1:0]         wt_r, wt_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic                    phase_r, phase_s;   // 0 = write, 1 = readback
    logic [15:0]             txn_r, txn_s;
    logic [7:0]              errc_r, errc_s;
    logic [7:0]              toc_r, toc_s;
    logic                    err_r, err_s;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == A_END) begin
            return A_BEG;
        end else begin
            return a + ADDR_WIDTH'(1);
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'h01;
        end
    endfunction

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_s = state_r;
        dly_s   = dly_r;
        wt_s    = wt_r;
        addr_s  = addr_r;
        data_s  = data_r;
        phase_s = phase_r;
        txn_s   = txn_r;
        errc_s  = errc_r;
        toc_s   = toc_r;
        err_s   = err_r;
        case (state_r)
            ST_WAIT: begin
                if (dly_r != DLY_MAX) begin
                    dly_s = dly_r + DLY_W'(1);
                end else if (enable) begin
                    state_s = ST_REQ;
                    wt_s    = '0;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_s = ST_WAIT;
                    dly_s   = '0;
                    txn_s   = txn_r + 16'd1;
                    if (CHECK_MODE && !phase_r) begin
                        phase_s = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        data_s  = data_r + DATA_WIDTH'(1);
                        addr_s  = next_addr(addr_r);
                        // Readback compare happens only on the read half of a pair.
                        if (CHECK_MODE && (dataR != data_r)) begin
                            errc_s = sat_inc8(errc_r);
                            err_s  = 1'b1;
                        end else begin
                            err_s  = err_r;
                        end
                    end
                end else if (wt_r == WT_LAST) begin
                    state_s = ST_WAIT;
                    dly_s   = '0;
                    toc_s   = sat_inc8(toc_r);
                end else begin
                    wt_s = wt_r + WT_W'(1);
                end
            end
            default: begin
                state_s = ST_WAIT;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT;
            dly_r   <= '0;
            wt_r    <= '0;
            addr_r  <= A_BEG;
            data_r  <= '0;
            phase_r <= 1'b0;
            txn_r   <= 16'd0;
            errc_r  <= 8'd0;
            toc_r   <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            dly_r   <= dly_s;
            wt_r    <= wt_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            phase_r <= phase_s;
            txn_r   <= txn_s;
            errc_r  <= errc_s;
            toc_r   <= toc_s;
            err_r   <= err_s;
        end
    end

    assign rq            = (state_r == ST_REQ);
    assign address       = rq ? addr_r : {ADDR_WIDTH{1'bz}};
    assign dataW         = rq ? data_r : {DATA_WIDTH{1'bz}};
    assign wr_ni         = rq ? (CHECK_MODE ? phase_r : addr_r[0]) : 1'bz;
    assign txn_count     = txn_r;
    assign err_count     = errc_r;
    assign timeout_count = toc_r;
    assign err           = err_r;

endmodule

// File: tb/tb_bus_client_gen.sv
// Bench running a legacy and a readback client in lock-step on shared control inputs,
// each checked against an index-based model of the expected bus traffic.
module tb_bus_client_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ack;
    logic [7:0]  dataR;

    wire  [3:0]  address0, address1;
    wire  [7:0]  dataW0, dataW1;
    wire         wr0, wr1;
    logic        rq0, rq1;
    logic [15:0] txn0, txn1;
    logic [7:0]  errc0, errc1, toc0, toc1;
    logic        err0, err1;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int exp_err = 0;
    int exp_to  = 0;
    int n;
    int hi;

    always #5 clk = ~clk;

    bus_client_gen #(.MODE(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .address(address0), .rq(rq0),
        .ack(ack), .wr_ni(wr0), .dataW(dataW0), .dataR(dataR), .txn_count(txn0),
        .err_count(errc0), .timeout_count(toc0), .err(err0)
    );

    bus_client_gen #(.MODE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .address(address1), .rq(rq1),
        .ack(ack), .wr_ni(wr1), .dataW(dataW1), .dataR(dataR), .txn_count(txn1),
        .err_count(errc1), .timeout_count(toc1), .err(err1)
    );

    // Expected traffic for completed-transaction index i.
    function automatic int m_addr(input int mode, input int i);
        return (mode == 0) ? (i % 4) : ((i / 2) % 4);
    endfunction
    function automatic int m_data(input int mode, input int i);
        return (mode == 0) ? (i % 256) : ((i / 2) % 256);
    endfunction
    function automatic int m_wr(input int mode, input int i);
        return (mode == 0) ? ((i % 4) & 1) : (i % 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rq0"}, {31'h0, rq0}, 32'h0);
        check({tag, "_rq1"}, {31'h0, rq1}, 32'h0);
        check({tag, "_addr0_z"}, {28'h0, address0}, {28'h0, {4{1'bz}}});
        check({tag, "_addr1_z"}, {28'h0, address1}, {28'h0, {4{1'bz}}});
        check({tag, "_dataw0_z"}, {24'h0, dataW0}, {24'h0, {8{1'bz}}});
        check({tag, "_dataw1_z"}, {24'h0, dataW1}, {24'h0, {8{1'bz}}});
        check({tag, "_wr0_z"}, {31'h0, wr0}, {31'h0, 1'bz});
        check({tag, "_wr1_z"}, {31'h0, wr1}, {31'h0, 1'bz});
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_txn0"}, {16'h0, txn0}, k);
        check({tag, "_txn1"}, {16'h0, txn1}, k);
        check({tag, "_errc0"}, {24'h0, errc0}, 32'h0);
        check({tag, "_errc1"}, {24'h0, errc1}, exp_err);
        check({tag, "_err1"}, {31'h0, err1}, {31'h0, (exp_err != 0)});
        check({tag, "_to0"}, {24'h0, toc0}, exp_to);
        check({tag, "_to1"}, {24'h0, toc1}, exp_to);
    endtask

    task automatic wait_rq(output int cnt);
        cnt = 0;
        while (rq0 !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    // Entered in the first REQ cycle; acks after lat further cycles.
    task automatic finish_txn(input int lat, input bit corrupt);
        for (int i = 0; i < lat; i++) tick();
        dataR = corrupt ? 8'hFF : 8'(m_data(1, k));
        ack   = 1'b1;
        check("ack_rq0", {31'h0, rq0}, 32'h1);
        check("ack_addr0", {28'h0, address0}, m_addr(0, k));
        check("ack_data0", {24'h0, dataW0}, m_data(0, k));
        check("ack_wr0", {31'h0, wr0}, m_wr(0, k));
        check("ack_addr1", {28'h0, address1}, m_addr(1, k));
        check("ack_data1", {24'h0, dataW1}, m_data(1, k));
        check("ack_wr1", {31'h0, wr1}, m_wr(1, k));
        tick();
        ack = 1'b0;
        if (m_wr(1, k) == 1 && corrupt && exp_err < 255) exp_err++;
        k++;
        check_idle("post_ack");
        check_counts("post_ack");
    endtask

    task automatic model_reset();
        k = 0;
        exp_err = 0;
        exp_to = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ack = 1'b0; dataR = 8'h00;
        tick(); tick(); tick();
        check_idle("reset");
        check_counts("reset");
        reset = 1'b0;

        // First request after REQUEST_DELAY+1 cycles, then the plain legacy sequence.
        wait_rq(n);
        check("first_rq_delay", n, 11);
        for (int t = 0; t < 5; t++) begin
            if (t != 0) begin
                wait_rq(n);
                check("rq_delay", n, 11);
            end
            finish_txn(2, 1'b0);
        end
        check("txn_after_5", {16'h0, txn0}, 32'd5);

        // Randomised latencies; the read of addr2 (index 5) returns FF, plus random corruption.
        for (int t = 0; t < 20; t++) begin
            wait_rq(n);
            check("rq_delay_rand", n, 11);
            finish_txn((t == 0) ? 14 : int'($urandom_range(0, 13)),
                       (k == 5) || ($urandom_range(0, 3) == 0));
        end

        // No ack: request abandoned after MAX_WAIT cycles, then retried unchanged.
        wait_rq(n);
        hi = 0;
        while (rq0 === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        exp_to = 1;
        check("timeout_rq_len", hi, 15);
        check_idle("timeout");
        check_counts("timeout");
        wait_rq(n);
        check("retry_delay", n, 11);
        finish_txn(0, 1'b0);

        // Enable gating from reset.
        reset = 1'b1; enable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        check_counts("reset2");
        hi = 0;
        repeat (50) begin
            tick();
            if (rq0 === 1'b1) hi++;
        end
        check("disabled_rq_cycles", hi, 0);
        enable = 1'b1;
        tick();
        check("enable_rq_rise", {31'h0, rq0}, 32'h1);
        tick();
        enable = 1'b0;
        finish_txn(1, 1'b0);
        hi = 0;
        repeat (30) begin
            tick();
            if (rq0 === 1'b1) hi++;
        end
        check("disabled_after_txn", hi, 0);

        // Reset two cycles into a request drops it.
        enable = 1'b1;
        wait_rq(n);
        tick();
        reset = 1'b1;
        tick();
        model_reset();
        check_idle("midreq_reset");
        check_counts("midreq_reset");
        reset = 1'b0;
        wait_rq(n);
        check("post_reset_delay", n, 11);
        finish_txn(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_client_gen.md
Name: bus_client_gen

Overview:
Parametrised next-generation bus client for the arbitrated shared bus. It uses the same rq/ack handshake and the same tri-stated address, data and wr_ni drive.
It adds three things:
- a selectable traffic mode: legacy, or write-then-readback with data checking;
- an enable gate;
- a request timeout with retry.
It keeps status counters for transactions, data mismatches and timeouts. Multiple instances sit on the shared bus as traffic generators and self-checkers for arbiter and server verification.

Parameters:
DATA_WIDTH, 8, width of dataW/dataR and the data pattern counter
ADDR_WIDTH, 4, address width
ADDR_SPACE_BEGINNING, 0, first address in this client's window
ADDR_SPACE_END, 3, last address in window (inclusive; must be >= ADDR_SPACE_BEGINNING)
REQUEST_DELAY, 10, idle cycles between transactions (0 allowed)
MODE, 0, 0 = legacy (wr_ni = addr[0]); 1 = write-then-readback-check
MAX_WAIT, 15, cycles rq may stay high without ack before abandoning (>= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
enable  input  1  1 = allowed to start new transactions
address  output  ADDR_WIDTH  bus address; Z when not requesting
rq  output  1  bus request (registered)
ack  input  1  grant/complete from arbiter/server
wr_ni  output  1  1 = read, 0 = write; Z when not requesting
dataW  output  DATA_WIDTH  write data; Z when not requesting
dataR  input  DATA_WIDTH  read data, valid in ack cycle of a read
txn_count  output  16  completed transactions, wraps
err_count  output  8  readback mismatches, saturates at 255
timeout_count  output  8  abandoned requests, saturates at 255
err  output  1  sticky, set on first mismatch

Behaviour:
- Reset (synchronous, all registers):
  - state = WAIT, delay counter = 0, rq = 0.
  - address register = ADDR_SPACE_BEGINNING, data register = 0, phase = WRITE.
  - All status counters = 0, err = 0.
- FSM has two states, WAIT and REQ. rq = (state == REQ), registered.
- WAIT:
  - Delay counter increments each cycle, saturating at REQUEST_DELAY.
  - When counter == REQUEST_DELAY and enable = 1: go to REQ and clear the wait counter.
  - With enable = 0 the FSM holds in WAIT.
  - First rq = 1 appears REQUEST_DELAY+1 cycles after reset is released.
- REQ:
  - address, dataW and wr_ni are driven for every cycle rq = 1, including the ack cycle. All three are Z in WAIT.
  - ack = 1 completes the transaction: next state WAIT, delay counter = 0, txn_count += 1, transaction register advances. rq = 0 on the following cycle.
  - ack observed while in WAIT is ignored.
  - Timeout: wait counter counts REQ cycles with ack = 0. When it reaches MAX_WAIT: go to WAIT, timeout_count += 1, transaction NOT advanced, so the identical transaction is retried after the delay.
  - If ack arrives in the same cycle the timeout is reached, the ack wins and no timeout is counted.
  - enable falling during REQ does not abort the transaction.
- MODE 0 (legacy):
  - wr_ni = address[0].
  - dataW = data register.
  - On completion: data += 1 (mod 2^DATA_WIDTH); address += 1, wrapping from ADDR_SPACE_END to ADDR_SPACE_BEGINNING.
- MODE 1 (write-then-readback):
  - Phase WRITE: wr_ni = 0, dataW = data register. On completion, phase = READ; address and data held.
  - Phase READ: wr_ni = 1, dataW = data register, driven but don't-care to the server.
  - At the ack cycle of a read: dataR is compared with the data register. On mismatch: err_count += 1 (saturating), err = 1.
  - After the read completes: phase = WRITE, data += 1, address advances with the same wrap as MODE 0.
- Status counter widths are fixed; saturation holds at 255 with no wrap. txn_count wraps 65535 -> 0.
- Reset asserted mid-REQ:
  - rq = 0 the next cycle and all outputs return to Z.
  - All state is cleared; any in-flight transaction is dropped and not counted.

Test Plan:
- MODE 0, defaults, enable = 1, ack pulsed 2 cycles after each rq rise:
  - rq first rises 11 cycles after reset.
  - Transactions go to addresses 0,1,2,3,0 with dataW 0,1,2,3,4 and wr_ni 0,1,0,1,0.
  - txn_count = 5; outputs are Z between requests.
- MODE 1, server echoes written data:
  - Sequence is write addr0/data0, read addr0, write addr1/data1, read addr1, and so on.
  - After 8 transactions: txn_count = 8, err_count = 0, err = 0.
- MODE 1, server returns dataR = 8'hFF on the read of addr2:
  - err_count = 1, err = 1.
  - err remains 1 after later correct reads; addr3 is still processed next.
- ack never asserted, MAX_WAIT = 15:
  - rq stays high 15 cycles then drops; timeout_count = 1.
  - Retry reuses the same address and data; ack on the retry gives txn_count = 1.
- enable = 0 from reset for 50 cycles, then 1:
  - No rq while disabled; rq rises the cycle after enable is sampled high.
  - Deassert enable mid-REQ: the transaction still completes on ack and no new rq follows.
- Reset asserted 2 cycles into REQ:
  - rq = 0 and all outputs Z the next cycle; all counters 0.
  - After release, addr = ADDR_SPACE_BEGINNING and data = 0.
